keypad_col_scan: RTL and testbench

Column-scanning 4x4 keypad reader for the candy vending machine front panel: the input-direction counterpart of the seven-segment column multiplexer. It drives one active-low keypad column at a time, samples the active-low row lines, debounces the press, and reports a 4-bit key code with a one-cycle valid strobe to the vending controller, which turns it into coin and candy selections.

---
 rtl/keypad_col_scan.sv | 192 +++++++++++++++++++
 tb/tb_keypad_col_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_col_scan.sv
// ============================================================================
// keypad_col_scan : 4x4 column-scanning keypad reader with press/release
// debounce. Optional auto-repeat enabled by defining KEYPAD_REPEAT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module keypad_col_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 250000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
    $error("keypad_col_scan: SCAN_DIV must be >= 2, counts must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [3:0]          row_meta_q,   row_meta_d;
  logic [3:0]          row_s_q,      row_s_d;
  logic [3:0]          key_column_q, key_column_d;
  logic [1:0]          col_idx_q,    col_idx_d;
  logic [1:0]          row_idx_q,    row_idx_d;
  logic [3:0]          key_code_q,   key_code_d;
  logic                key_valid_q,  key_valid_d;
  logic                key_held_q,   key_held_d;
  logic [SCAN_W-1:0]   scan_cnt_q,   scan_cnt_d;
  logic [DEB_W-1:0]    stab_cnt_q,   stab_cnt_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  logic [REP_W-1:0]    rep_cnt_q,    rep_cnt_d;
`endif

  logic row_bit;

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    casez (rows)
      4'b???0: lowest_low = 2'd0;
      4'b??01: lowest_low = 2'd1;
      4'b?011: lowest_low = 2'd2;
      default: lowest_low = 2'd3;
    endcase
  endfunction

  assign row_bit = row_s_q[row_idx_q];

  always_comb begin
    state_d      = state_q;
    row_meta_d   = key_row;
    row_s_d      = row_meta_q;
    key_column_d = key_column_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    scan_cnt_d   = scan_cnt_q;
    stab_cnt_d   = stab_cnt_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d    = '0;
`endif

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
          scan_cnt_d = '0;
          if (&row_s_q) begin
            col_idx_d    = col_idx_q + 2'd1;
            key_column_d = {key_column_q[2:0], key_column_q[3]};
          end else begin
            row_idx_d  = lowest_low(row_s_q);
            stab_cnt_d = '0;
            state_d    = ST_DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (row_bit) begin
          // Bounce: give up on this key and move on to the next column.
          stab_cnt_d   = '0;
          scan_cnt_d   = '0;
          col_idx_d    = col_idx_q + 2'd1;
          key_column_d = {key_column_q[2:0], key_column_q[3]};
          state_d      = ST_SCAN;
        end else if (stab_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
          stab_cnt_d  = '0;
          key_code_d  = {col_idx_q, row_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_HELD;
        end else begin
          stab_cnt_d = stab_cnt_q + DEB_W'(1);
        end
      end

      ST_HELD: begin
        if (!row_bit) begin
          stab_cnt_d = '0;
        end else if (stab_cnt_q == DEB_W'(DEBOUNCE_CNT - 1)) begin
          stab_cnt_d   = '0;
          scan_cnt_d   = '0;
          key_held_d   = 1'b0;
          col_idx_d    = col_idx_q + 2'd1;
          key_column_d = {key_column_q[2:0], key_column_q[3]};
          state_d      = ST_SCAN;
        end else begin
          stab_cnt_d = stab_cnt_q + DEB_W'(1);
        end
`ifdef KEYPAD_REPEAT_EN
        // Counter waits at its terminal value while a release count runs.
        if (state_d == ST_HELD) begin
          if (rep_cnt_q == REP_W'(REPEAT_CNT - 1)) begin
            rep_cnt_d = rep_cnt_q;
            if (!row_bit) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = '0;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
`endif
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SCAN;
      row_meta_q   <= 4'b1111;
      row_s_q      <= 4'b1111;
      key_column_q <= 4'b1110;
      col_idx_q    <= 2'd0;
      row_idx_q    <= 2'd0;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      scan_cnt_q   <= '0;
      stab_cnt_q   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_meta_q   <= row_meta_d;
      row_s_q      <= row_s_d;
      key_column_q <= key_column_d;
      col_idx_q    <= col_idx_d;
      row_idx_q    <= row_idx_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      scan_cnt_q   <= scan_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q    <= rep_cnt_d;
`endif
    end
  end

  assign key_column = key_column_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_col_scan.sv
// ============================================================================
// tb_keypad_col_scan : scoreboard bench for keypad_col_scan with a physical
// keypad model (pressed switch matrix). Revision 1.0
// ============================================================================
`default_nettype none

module tb_keypad_col_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CNT   = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_PULSES   = 3;
`else
  localparam int REP_PULSES   = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_row;
  logic [3:0] key_column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;        // bit c*4+r: switch at column c, row r closed
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_exp;
  int          total = 0;
  int          bad   = 0;

  keypad_col_scan #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_CNT  (REPEAT_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_row   (key_row),
    .key_column(key_column),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #10 clk = ~clk;

  // A closed switch pulls its row low only while its column is driven low.
  always_comb begin
    key_row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!key_column[c] && pressed[c*4+r]) key_row[r] = 1'b0;
  end

  function automatic logic [3:0] col_drive(input int c);
    logic [3:0] one;
    one = 4'b0001 << (c % 4);
    return ~one;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got code=%0h want no strobe at %0t", key_code, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (key_code !== mon_exp || key_held !== 1'b1) begin
          bad++;
          $display("FAIL strobe got code=%0h held=%0b want code=%0h held=1 at %0t",
                   key_code, key_held, mon_exp, $time);
        end
      end
    end
  end

  task automatic do_press(input int c, input logic [3:0] mask, input int npulse);
    int r;
    r = 0;
    while (!mask[r]) r++;
    for (int i = 0; i < npulse; i++) exp_q.push_back({2'(c), 2'(r)});
    for (int i = 0; i < 4; i++) if (mask[i]) pressed[c*4+i] = 1'b1;
  endtask

  task automatic wait_accept(input int c);
    int n;
    n = 0;
    while (!key_held && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(key_held), 32'd1);
    chk("frozen_column", 32'(key_column), 32'(col_drive(c)));
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_release(input int c);
    int n;
    for (int i = 0; i < 4; i++) pressed[c*4+i] = 1'b0;
    n = 0;
    while (key_held && n < 40) begin
      @(negedge clk);
      n++;
    end
    // 2 synchronizer edges + DEBOUNCE_CNT high samples, registered output.
    chk("release_latency", 32'(n), 32'(2 + DEBOUNCE_CNT));
    chk("resume_column", 32'(key_column), 32'(col_drive(c + 1)));
    chk("all_strobes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c;
    logic [3:0] mask;
    pressed = '0;
    reset   = 1'b1;
    @(negedge clk);

    // Reset state, then column rotation every SCAN_DIV cycles.
    chk("reset_code", 32'(key_code), 32'd0);
    chk("reset_valid", 32'(key_valid), 32'd0);
    chk("reset_held", 32'(key_held), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5 * SCAN_DIV; i++) begin
      chk("scan_column", 32'(key_column), 32'(col_drive(i / SCAN_DIV)));
      @(negedge clk);
    end

    // Clean press: column 2, row 1.
    do_press(2, 4'b0010, 1);
    wait_accept(2);
    chk("clean_code", 32'(key_code), 32'h9);
    hold_cycles(10);
    do_release(2);

    // Bounce on column 0 row 0: 5 synchronized low cycles, no strobe.
    begin
      int n;
      n = 0;
      while (key_column != 4'b1110 && n < 40) begin
        @(negedge clk);
        n++;
      end
      while (key_column == 4'b1110 && n < 40) begin
        @(negedge clk);
        n++;
      end
      while (key_column != 4'b1110 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("bounce_sync_column", 32'(key_column), 32'h0000_000e);
    end
    pressed[0] = 1'b1;
    hold_cycles(5);
    pressed[0] = 1'b0;
    hold_cycles(2);
    chk("bounce_frozen", 32'(key_column), 32'(col_drive(0)));
    hold_cycles(1);
    chk("bounce_next_col", 32'(key_column), 32'(col_drive(1)));
    chk("bounce_not_held", 32'(key_held), 32'd0);
    hold_cycles(2 * SCAN_DIV);

    // Two keys in column 3: lowest row wins, partial release keeps it held.
    do_press(3, 4'b1100, 1);
    wait_accept(3);
    chk("two_key_code", 32'(key_code), 32'hE);
    hold_cycles(2);
    pressed[3*4+3] = 1'b0;
    hold_cycles(12);
    chk("partial_release_held", 32'(key_held), 32'd1);
    do_release(3);

    // Randomized presses, possibly several rows in one column.
    for (int t = 0; t < 8; t++) begin
      c    = int'($urandom_range(0, 3));
      mask = 4'($urandom_range(1, 15));
      do_press(c, mask, 1);
      wait_accept(c);
      hold_cycles(int'($urandom_range(2, 12)));
      do_release(c);
    end

    // Repeat: column 1 row 3 held 50 cycles after accept.
    do_press(1, 4'b1000, REP_PULSES);
    wait_accept(1);
    chk("repeat_code", 32'(key_code), 32'h7);
    hold_cycles(50);
    do_release(1);

    // Reset in the middle of a hold.
    do_press(2, 4'b0001, 1);
    wait_accept(2);
    hold_cycles(3);
    reset = 1'b1;
    @(negedge clk);
    pressed = '0;
    chk("midreset_held", 32'(key_held), 32'd0);
    chk("midreset_code", 32'(key_code), 32'd0);
    chk("midreset_column", 32'(key_column), 32'he);
    reset = 1'b0;
    hold_cycles(20);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
